// File: rtl/usb_hid_led_sched.sv
// Schedules keyboard LED SET_REPORT requests to the USB host core. It merges register strobes
// that arrive close together, waits for a keyboard, and handles timeout, retry and holdoff.
module usb_hid_led_sched #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned MAX_RETRIES    = 3,
  parameter int unsigned HOLDOFF_CYCLES = 1000
) (
  input  logic       wb_clk,
  input  logic       wb_rst,
  input  logic       update_leds_stb,
  input  logic [3:0] leds,
  output logic       ack_update_leds_stb,
  input  logic [1:0] usb_typ,
  output logic       usb_led_req,
  output logic [3:0] usb_led_val,
  input  logic       usb_led_gnt,
  input  logic       usb_led_done,
  output logic       led_fail,
  output logic       led_pending
);

  localparam int unsigned TimerW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned HoldW  = $clog2(HOLDOFF_CYCLES + 1);
  localparam int unsigned RetryW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

  localparam logic [TimerW-1:0] TimerLast = TimerW'(TIMEOUT_CYCLES - 1);
  localparam logic [HoldW-1:0]  HoldLast  = HoldW'(HOLDOFF_CYCLES - 1);
  localparam logic [RetryW-1:0] RetryMax  = RetryW'(MAX_RETRIES);

  typedef enum logic [2:0] {StIdle, StWaitKbd, StReq, StWaitDone, StHoldoff} state_e;

  state_e            state_q, state_d;
  logic [3:0]        next_leds_q, next_leds_d;
  logic [3:0]        cur_leds_q, cur_leds_d;
  logic              pending_q, pending_d;
  logic [RetryW-1:0] retry_q, retry_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic [HoldW-1:0]  hold_q, hold_d;
  logic              ack_q, ack_d;
  logic              fail_q, fail_d;
  logic              kbd;

  assign kbd = (usb_typ == 2'd1);

  always_comb begin
    state_d     = state_q;
    next_leds_d = next_leds_q;
    cur_leds_d  = cur_leds_q;
    pending_d   = pending_q;
    retry_d     = retry_q;
    timer_d     = timer_q;
    hold_d      = hold_q;
    ack_d       = 1'b0;
    fail_d      = fail_q;

    if (update_leds_stb) begin
      next_leds_d = leds;
      pending_d   = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (pending_q || update_leds_stb) state_d = StWaitKbd;
      end
      StWaitKbd: begin
        if (kbd) begin
          state_d    = StReq;
          cur_leds_d = next_leds_q;
          retry_d    = '0;
          if (!update_leds_stb) pending_d = 1'b0;
        end
      end
      StReq: begin
        if (!kbd) begin
          // Keyboard gone: requeue the in-flight value unless a fresh one just arrived.
          state_d   = StWaitKbd;
          pending_d = 1'b1;
          if (!update_leds_stb) next_leds_d = cur_leds_q;
        end else if (usb_led_gnt) begin
          state_d = StWaitDone;
          timer_d = '0;
        end
      end
      StWaitDone: begin
        timer_d = timer_q + TimerW'(1);
        if (usb_led_done) begin
          state_d = StHoldoff;
          hold_d  = '0;
          ack_d   = 1'b1;
          fail_d  = 1'b0;
        end else if (!kbd) begin
          state_d   = StWaitKbd;
          pending_d = 1'b1;
          if (!update_leds_stb) next_leds_d = cur_leds_q;
        end else if (timer_q == TimerLast) begin
          if (retry_q < RetryMax) begin
            state_d = StReq;
            retry_d = retry_q + RetryW'(1);
            // A newer value supersedes the one being retried.
            if (pending_q) begin
              cur_leds_d = next_leds_q;
              if (!update_leds_stb) pending_d = 1'b0;
            end
          end else begin
            state_d = StHoldoff;
            hold_d  = '0;
            ack_d   = 1'b1;
            fail_d  = 1'b1;
          end
        end
      end
      StHoldoff: begin
        if (hold_q == HoldLast) state_d = StIdle;
        else hold_d = hold_q + HoldW'(1);
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      state_q     <= StIdle;
      next_leds_q <= '0;
      cur_leds_q  <= '0;
      pending_q   <= 1'b0;
      retry_q     <= '0;
      timer_q     <= '0;
      hold_q      <= '0;
      ack_q       <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      next_leds_q <= next_leds_d;
      cur_leds_q  <= cur_leds_d;
      pending_q   <= pending_d;
      retry_q     <= retry_d;
      timer_q     <= timer_d;
      hold_q      <= hold_d;
      ack_q       <= ack_d;
      fail_q      <= fail_d;
    end
  end

  assign usb_led_req         = (state_q == StReq);
  assign usb_led_val         = cur_leds_q;
  assign ack_update_leds_stb = ack_q;
  assign led_fail            = fail_q;
  assign led_pending         = pending_q;

endmodule

// File: tb/tb_usb_hid_led_sched.sv
// Directed bench for usb_hid_led_sched: latency, coalescing, retry/timeout, holdoff, detach
// and reset abandon, all with hand-computed expectations.
module tb_usb_hid_led_sched;

  localparam int unsigned Timeout = 50;
  localparam int unsigned Retries = 2;
  localparam int unsigned Holdoff = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       stb = 1'b0;
  logic [3:0] leds = '0;
  logic       ack;
  logic [1:0] typ = 2'd0;
  logic       req;
  logic [3:0] val;
  logic       gnt = 1'b0;
  logic       done = 1'b0;
  logic       fail;
  logic       pend;

  int checks = 0;
  int failures = 0;
  int ack_cnt = 0;

  usb_hid_led_sched #(
    .TIMEOUT_CYCLES(Timeout),
    .MAX_RETRIES   (Retries),
    .HOLDOFF_CYCLES(Holdoff)
  ) dut (
    .wb_clk             (clk),
    .wb_rst             (rst),
    .update_leds_stb    (stb),
    .leds               (leds),
    .ack_update_leds_stb(ack),
    .usb_typ            (typ),
    .usb_led_req        (req),
    .usb_led_val        (val),
    .usb_led_gnt        (gnt),
    .usb_led_done       (done),
    .led_fail           (fail),
    .led_pending        (pend)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (ack === 1'b1) ack_cnt <= ack_cnt + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic strobe(input logic [3:0] v);
    stb  = 1'b1;
    leds = v;
    step();
    stb  = 1'b0;
  endtask

  task automatic wait_req(input string tag, input int max);
    bit ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      if (req === 1'b1) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    check(tag, 32'(ok), 32'd1);
  endtask

  task automatic pulse_gnt();
    gnt = 1'b1;
    step();
    gnt = 1'b0;
  endtask

  task automatic pulse_done();
    done = 1'b1;
    step();
    done = 1'b0;
  endtask

  initial begin
    int a0;
    int n;
    int gnts;
    int gt[3];
    bit seen_req;

    step(3);
    rst = 1'b0;
    check("rst_req", 32'(req), 0);
    check("rst_ack", 32'(ack), 0);
    check("rst_fail", 32'(fail), 0);
    check("rst_pend", 32'(pend), 0);
    check("rst_val", 32'(val), 0);

    // Basic transaction: req two edges after the strobe edge.
    typ = 2'd1;
    a0 = ack_cnt;
    strobe(4'h2);
    check("t1_req_early", 32'(req), 0);
    step();
    check("t1_req", 32'(req), 1);
    check("t1_val", 32'(val), 4'h2);
    step();
    pulse_gnt();
    step(9);
    pulse_done();
    check("t1_ack_pulse", 32'(ack), 1);
    check("t1_fail", 32'(fail), 0);
    step();
    check("t1_ack_low", 32'(ack), 0);
    check("t1_ack_cnt", 32'(ack_cnt - a0), 1);
    step(Holdoff + 2);

    // Coalescing while no keyboard.
    typ = 2'd0;
    a0 = ack_cnt;
    seen_req = 1'b0;
    strobe(4'h1);
    step(2);
    strobe(4'h5);
    for (int i = 0; i < 6; i++) begin
      if (req === 1'b1) seen_req = 1'b1;
      step();
    end
    check("t2_no_req", 32'(seen_req), 0);
    check("t2_pend", 32'(pend), 1);
    typ = 2'd1;
    wait_req("t2_req", 5);
    check("t2_val", 32'(val), 4'h5);
    check("t2_pend_clr", 32'(pend), 0);
    pulse_gnt();
    step(3);
    pulse_done();
    step(Holdoff + 4);
    check("t2_ack_cnt", 32'(ack_cnt - a0), 1);
    check("t2_no_resend", 32'(req), 0);

    // Timeout with retries.
    a0 = ack_cnt;
    gnts = 0;
    strobe(4'h7);
    for (int c = 0; c < 200; c++) begin
      gnt = 1'b0;
      if (req === 1'b1) begin
        gnt = 1'b1;
        if (gnts < 3) gt[gnts] = c;
        gnts++;
      end
      step();
    end
    gnt = 1'b0;
    check("t3_gnts", 32'(gnts), 3);
    check("t3_gap1", 32'(gt[1] - gt[0]), Timeout + 1);
    check("t3_gap2", 32'(gt[2] - gt[1]), Timeout + 1);
    check("t3_ack_cnt", 32'(ack_cnt - a0), 1);
    check("t3_fail", 32'(fail), 1);

    // Strobe during WAIT_DONE queues a second transaction after holdoff.
    a0 = ack_cnt;
    strobe(4'h9);
    wait_req("t4_req1", 5);
    pulse_gnt();
    step(3);
    strobe(4'h3);
    check("t4_pend", 32'(pend), 1);
    step(2);
    pulse_done();
    check("t4_ack", 32'(ack), 1);
    check("t4_fail_clr", 32'(fail), 0);
    n = 0;
    while (req !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    check("t4_holdoff_gap", 32'(n), Holdoff + 2);
    check("t4_val", 32'(val), 4'h3);
    pulse_gnt();
    step(2);
    pulse_done();
    step(Holdoff + 4);
    check("t4_ack_cnt", 32'(ack_cnt - a0), 2);

    // Detach during WAIT_DONE requeues the same value.
    a0 = ack_cnt;
    strobe(4'h4);
    wait_req("t5_req1", 5);
    pulse_gnt();
    step(2);
    typ = 2'd0;
    step(4);
    check("t5_pend", 32'(pend), 1);
    check("t5_req_low", 32'(req), 0);
    check("t5_no_ack", 32'(ack_cnt - a0), 0);
    typ = 2'd1;
    wait_req("t5_req2", 5);
    check("t5_val", 32'(val), 4'h4);
    pulse_gnt();
    step(2);
    pulse_done();
    step(Holdoff + 4);
    check("t5_ack_cnt", 32'(ack_cnt - a0), 1);

    // Reset mid-transaction abandons it.
    a0 = ack_cnt;
    strobe(4'h6);
    wait_req("t6_req1", 5);
    pulse_gnt();
    step(2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    pulse_done();
    check("t6_req", 32'(req), 0);
    check("t6_val", 32'(val), 0);
    check("t6_pend", 32'(pend), 0);
    check("t6_fail", 32'(fail), 0);
    seen_req = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (req === 1'b1) seen_req = 1'b1;
      step();
    end
    check("t6_idle", 32'(seen_req), 0);
    check("t6_no_ack", 32'(ack_cnt - a0), 0);
    strobe(4'hA);
    wait_req("t6_req2", 5);
    check("t6_val2", 32'(val), 4'hA);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
